vec_mem_seq: RTL
================

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 16, elements per vector transfer.
REQ-002 SHALL have parameter WIDTH, default 16, bits per element, memory word and address.
REQ-003 Clk1  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request pulse; sampled only when Busy=0.
REQ-006 Store  input  1  1 = vector store (register to memory), 0 = vector load; latched at Start.
REQ-007 BaseAddr  input  WIDTH  first memory address; latched at Start.
REQ-008 Stride  input  WIDTH  address increment per element; latched at Start.
REQ-009 VRdData  input  WIDTH  vector-file element selected by VIdx (combinational lookup, store path).
REQ-010 DataIn  input  WIDTH  DRAM read data, valid the cycle after RD.
REQ-011 Addr  output  WIDTH  DRAM address.
REQ-012 RD  output  1  DRAM read strobe.
REQ-013 WR  output  1  DRAM write strobe.
REQ-014 DataOut  output  WIDTH  DRAM write data.
REQ-015 VIdx  output  log2(NUM_ELEM)  element index for vector-file read or write.
REQ-016 VWrEn  output  1  vector-file element write enable (load path).
REQ-017 VWrData  output  WIDTH  vector-file write data.
REQ-018 Busy  output  1  transfer in progress.
REQ-019 Done  output  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, LOAD, LDRAIN, STORE; Busy=1 in every state except IDLE.
REQ-021 IDLE + Start=1 SHALL latch Store/BaseAddr/Stride, clear element counter k, go to LOAD (Store=0) or STORE (Store=1).
REQ-022 Start while Busy=1, including the Done cycle, SHALL be ignored without effect.
REQ-023 Element address SHALL be BaseAddr + k*Stride modulo 2^WIDTH; wrap-around is silent.
REQ-024 LOAD: cycle k (k=0..NUM_ELEM-1 after entry) SHALL drive RD=1, WR=0, Addr = element k address.
REQ-025 LOAD: cycle k>=1 SHALL drive VWrEn=1, VIdx=k-1, VWrData=DataIn (from read k-1); cycle 0 VWrEn=0.
REQ-026 After element NUM_ELEM-1 is issued, SHALL go to LDRAIN for one cycle: RD=0, VWrEn=1, VIdx=NUM_ELEM-1, VWrData=DataIn, Done=1; then IDLE.
REQ-027 Load latency SHALL be: Start at edge 0 -> RD cycles 1..NUM_ELEM -> VWrEn cycles 2..NUM_ELEM+1 -> Done at cycle NUM_ELEM+1.
REQ-028 STORE: cycle k SHALL drive WR=1, RD=0, VIdx=k, Addr = element k address, DataOut=VRdData (combinational pass-through).
REQ-029 STORE: Done=1 SHALL coincide with the WR of element NUM_ELEM-1; next state IDLE.
REQ-030 Store latency SHALL be: Start at edge 0 -> WR cycles 1..NUM_ELEM -> Done at cycle NUM_ELEM.
REQ-031 RD and WR SHALL never be high together; VWrEn SHALL never be high in STORE.
REQ-032 In IDLE, RD, WR, VWrEn, Done SHALL be 0; DataOut SHALL be 0 whenever WR=0.
REQ-033 Addr, RD, WR, VIdx, Busy, Done SHALL be registered outputs; DataOut and VWrData SHALL be data pass-throughs gated as above.

Reset
REQ-034 Reset=1 SHALL force IDLE, k=0, and next cycle Addr=0, RD=0, WR=0, DataOut=0, VIdx=0, VWrEn=0, VWrData=0, Busy=0, Done=0.
REQ-035 Reset SHALL take priority over Start in the same cycle.
REQ-036 Reset mid-transfer SHALL abort at once: no further RD/WR/VWrEn, no Done pulse; partial memory/register writes remain.

Verification
REQ-037 Load, BaseAddr=0x0100, Stride=1, mem[0x100+i]=0xA000+i -> RD at 0x0100..0x010F in cycles 1..16; VWrEn element i = 0xA000+i in cycle i+2; Done cycle 17 only.
REQ-038 Store, BaseAddr=0x0200, Stride=2, VRdData(i)=0x1111*i -> WR at 0x0200,0x0202..0x021E in cycles 1..16 with DataOut=0x1111*i; Done cycle 16; memory dump matches.
REQ-039 Wrap: load BaseAddr=0xFFFC, Stride=1 -> addresses FFFC,FFFD,FFFE,FFFF,0000..000B.
REQ-040 Start pulsed at cycle 5 and in Done cycle of a load -> ignored; exactly 16 reads; Busy falls cycle 18.
REQ-041 Reset asserted in store cycle 7 -> element 0..6 written only (WR cycles 1..7), all outputs 0 next cycle, no Done; subsequent Start completes normally.
REQ-042 Back-to-back: store Start in first IDLE cycle after load Done -> WR begins next cycle; RD/WR never overlap.

Source files
------------

// File: rtl/vec_mem_seq.sv
// -----------------------------------------------------------------------------
// vec_mem_seq
//   Sequencer that moves one vector (NUM_ELEM elements) between a vector
//   register file and a word-addressed DRAM. Each element k lives at address
//   BaseAddr + k*Stride (mod 2^WIDTH).
//
//   Load  : issues NUM_ELEM reads on consecutive cycles. The data for read k
//           returns one cycle later and is written into vector element k. A
//           single drain cycle after the last read writes the final element
//           and pulses Done.
//   Store : issues NUM_ELEM writes on consecutive cycles. DataOut is the
//           vector-file element selected by VIdx, passed straight through.
//           Done coincides with the last write.
//
// Ports
//   i_clk1       : sole clock, rising edge
//   i_reset      : synchronous active-high reset
//   i_start      : request pulse, honoured only when idle
//   i_store      : 1 = store (vector -> memory), 0 = load
//   i_base_addr  : first element address
//   i_stride     : address increment per element
//   i_vrd_data   : vector-file element selected by o_vidx (store path)
//   i_data_in    : DRAM read data, valid the cycle after o_rd
//   o_addr       : DRAM address (registered)
//   o_rd / o_wr  : DRAM read / write strobes (registered)
//   o_data_out   : DRAM write data, zero unless o_wr
//   o_vidx       : vector-file element index (registered)
//   o_vwr_en     : vector-file write enable (registered)
//   o_vwr_data   : vector-file write data, zero unless o_vwr_en
//   o_busy       : transfer in progress (registered)
//   o_done       : one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module vec_mem_seq #(
    parameter int NUM_ELEM = 16,
    parameter int WIDTH    = 16,
    localparam int IDX_W   = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
    input  logic             i_clk1,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_store,
    input  logic [WIDTH-1:0] i_base_addr,
    input  logic [WIDTH-1:0] i_stride,
    input  logic [WIDTH-1:0] i_vrd_data,
    input  logic [WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0] o_addr,
    output logic             o_rd,
    output logic             o_wr,
    output logic [WIDTH-1:0] o_data_out,
    output logic [IDX_W-1:0] o_vidx,
    output logic             o_vwr_en,
    output logic [WIDTH-1:0] o_vwr_data,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_LDRAIN = 2'd2;
    localparam logic [1:0] S_STORE  = 2'd3;

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_ELEM - 1);
    localparam logic [IDX_W-1:0] K_ONE  = IDX_W'(1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_k;        // element currently being issued
    logic [WIDTH-1:0] r_stride;
    logic [WIDTH-1:0] r_addr;     // running address; modular add gives silent wrap
    logic             r_rd;
    logic             r_wr;
    logic [IDX_W-1:0] r_vidx;
    logic             r_vwr_en;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge i_clk1) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_stride <= '0;
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_vidx   <= '0;
            r_vwr_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_stride <= i_stride;
                        r_addr   <= i_base_addr;
                        r_k      <= '0;
                        r_vidx   <= '0;
                        r_busy   <= 1'b1;
                        if (i_store) begin
                            r_state <= S_STORE;
                            r_wr    <= 1'b1;
                            // A one-element store finishes on its first write.
                            r_done  <= (NUM_ELEM == 1);
                        end else begin
                            r_state <= S_LOAD;
                            r_rd    <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    // Every cycle after the first read, the previous read's
                    // data is on i_data_in and lands in element r_k.
                    r_vwr_en <= 1'b1;
                    r_vidx   <= r_k;
                    if (r_k == K_LAST) begin
                        r_state <= S_LDRAIN;
                        r_rd    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_k    <= r_k + K_ONE;
                        r_addr <= r_addr + r_stride;
                    end
                end

                S_LDRAIN: begin
                    r_state  <= S_IDLE;
                    r_vwr_en <= 1'b0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                end

                S_STORE: begin
                    if (r_k == K_LAST) begin
                        r_state <= S_IDLE;
                        r_wr    <= 1'b0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_k    <= r_k + K_ONE;
                        r_vidx <= r_k + K_ONE;
                        r_addr <= r_addr + r_stride;
                        // Done rides with the last element's write.
                        r_done <= ((r_k + K_ONE) == K_LAST);
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_rd     <= 1'b0;
                    r_wr     <= 1'b0;
                    r_vwr_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign o_addr     = r_addr;
    assign o_rd       = r_rd;
    assign o_wr       = r_wr;
    assign o_vidx     = r_vidx;
    assign o_vwr_en   = r_vwr_en;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

    // Data paths are combinational pass-throughs, forced to zero when unused.
    assign o_data_out = r_wr     ? i_vrd_data : '0;
    assign o_vwr_data = r_vwr_en ? i_data_in  : '0;

endmodule
